// File: rtl/network_source_batched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_source_batched_pkg
// Description : Dispatch opcodes and width helpers for the batched network
//               source (prefix width, slot index/slot/run-count widths).
// Revision    : 1.0 - initial release
// ============================================================================
package network_source_batched_pkg;

  // Opcode prefix occupies the top PFX_WIDTH bits of every packet.
  localparam int PFX_WIDTH = 3;

  // Dispatch opcodes; unlisted encodings are treated like NOP.
  typedef enum logic [PFX_WIDTH-1:0] {
    OP_NOP = 3'd0,
    OP_RUN = 3'd1,
    OP_SPK = 3'd2,
    OP_CLR = 3'd3,
    OP_FIN = 3'd4
  } opcode_t;

  // Neuron index field width: max(1, clog2(num_inp)).
  function automatic int idx_width(input int num_inp);
    return (num_inp <= 2) ? 1 : $clog2(num_inp);
  endfunction

  // One spike slot is {vld, idx, charge}.
  function automatic int slot_width(input int num_inp, input int charge_width);
    return 1 + idx_width(num_inp) + charge_width;
  endfunction

  // RUN/FIN count field is everything below the opcode.
  function automatic int run_width(input int pkt_width);
    return pkt_width - PFX_WIDTH;
  endfunction

endpackage : network_source_batched_pkg
`default_nettype wire

// File: rtl/network_source_batched_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : network_source_batched_sat_add
// Description : Combinational two's-complement saturating adder. Result is
//               clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; clip flags a clamp.
// Revision    : 1.0 - initial release
// ============================================================================
module network_source_batched_sat_add #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    clip
);

  logic [WIDTH:0] wide;

  // One guard bit: overflow shows up as the two top bits disagreeing.
  assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign clip = wide[WIDTH] ^ wide[WIDTH-1];

  // On overflow the guard bit carries the true sign of the result.
  assign sum = clip ? (wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}})
                    : wide[WIDTH-1:0];

endmodule : network_source_batched_sat_add
`default_nettype wire

// File: rtl/network_source_batched.sv
`default_nettype none
// ============================================================================
// Module      : network_source_batched
// Description : Decodes dispatch packets (NOP/RUN/SPK/CLR/FIN) into per-
//               timestep network input frames. SPK packets carry several
//               spike slots that build a pending frame while the current run
//               streams; RUN/FIN promote the pending frame to the output.
// Revision    : 1.0 - initial release
// ============================================================================
module network_source_batched
  import network_source_batched_pkg::*;
#(
  parameter int PKT_WIDTH    = 32,
  parameter int SPK_PER_PKT  = 2,
  parameter int ACCUMULATE   = 1,
  parameter int NUM_INP      = 4,
  parameter int CHARGE_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  src_valid,
  output logic                                  src_ready,
  input  logic [PKT_WIDTH-1:0]                  src,
  input  logic                                  net_ready,
  output logic                                  net_valid,
  output logic                                  net_last,
  output logic                                  net_rst,
  // Two's-complement charge per input neuron, element i = neuron i.
  output logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]  net_inp,
  output logic                                  sat_flag
);

  localparam int IDX_WIDTH  = idx_width(NUM_INP);
  localparam int SLOT_WIDTH = slot_width(NUM_INP, CHARGE_WIDTH);
  localparam int RUN_WIDTH  = run_width(PKT_WIDTH);

  opcode_t                               op;
  logic [RUN_WIDTH-1:0]                  run_n;
  logic [RUN_WIDTH-1:0]                  run_counter;
  logic                                  last;
  logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]  pend;
  logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]  pend_next;
  logic [NUM_INP-1:0][SPK_PER_PKT-1:0]   clip_hits;

  logic [SPK_PER_PKT-1:0]                   slot_vld;
  logic [SPK_PER_PKT-1:0][IDX_WIDTH-1:0]    slot_idx;
  logic [SPK_PER_PKT-1:0][CHARGE_WIDTH-1:0] slot_chg;

  logic accept;
  logic ctrl_ok;
  logic load;
  logic clr_acc;
  logic spk_acc;
  logic spk_clip;
  logic hs;

  assign op    = opcode_t'(src[PKT_WIDTH-1 -: PFX_WIDTH]);
  assign run_n = src[RUN_WIDTH-1:0];

  assign net_valid = (run_counter != '0);
  assign net_last  = last && (run_counter == RUN_WIDTH'(1));
  assign hs        = net_valid && net_ready;

  // RUN/FIN may enter on the final beat of a run so runs chain without a bubble.
  assign ctrl_ok = (run_counter == '0) || ((run_counter == RUN_WIDTH'(1)) && net_ready);

  // Readiness depends on the offered opcode only, never on src_valid.
  always_comb begin
    src_ready = 1'b1;
    case (op)
      OP_RUN, OP_FIN: src_ready = ctrl_ok;
      OP_CLR:         src_ready = (run_counter == '0);
      default:        src_ready = 1'b1;
    endcase
  end

  assign accept  = src_valid && src_ready;
  assign load    = accept && ((op == OP_RUN) || (op == OP_FIN)) && (run_n != '0);
  assign clr_acc = accept && (op == OP_CLR);
  assign spk_acc = accept && (op == OP_SPK);
  assign spk_clip = |clip_hits;

  // Unpack the spike slots of the current packet.
  for (genvar k = 0; k < SPK_PER_PKT; k++) begin : g_slot_fields
    assign slot_chg[k] = src[k*SLOT_WIDTH +: CHARGE_WIDTH];
    assign slot_idx[k] = src[k*SLOT_WIDTH + CHARGE_WIDTH +: IDX_WIDTH];
    assign slot_vld[k] = src[k*SLOT_WIDTH + CHARGE_WIDTH + IDX_WIDTH];
  end

  // Per neuron, slots are applied in ascending order so the highest slot
  // wins on overwrite and duplicates chain through the adders on accumulate.
  // An out-of-range index never matches any neuron and is thereby ignored.
  for (genvar i = 0; i < NUM_INP; i++) begin : g_inp
    for (genvar k = 0; k < SPK_PER_PKT; k++) begin : g_slot
      logic [CHARGE_WIDTH-1:0] prev;
      logic [CHARGE_WIDTH-1:0] nxt;
      logic [CHARGE_WIDTH-1:0] sum;
      logic                    clip;
      logic                    hit;

      if (k == 0) begin : g_first
        assign prev = pend[i];
      end else begin : g_chain
        assign prev = g_slot[k-1].nxt;
      end

      assign hit = slot_vld[k] && (slot_idx[k] == IDX_WIDTH'(i));

      network_source_batched_sat_add #(
        .WIDTH (CHARGE_WIDTH)
      ) u_sat_add (
        .a    (prev),
        .b    (slot_chg[k]),
        .sum  (sum),
        .clip (clip)
      );

      assign nxt = hit ? ((ACCUMULATE != 0) ? sum : slot_chg[k]) : prev;
      assign clip_hits[i][k] = hit && (ACCUMULATE != 0) && clip;
    end

    assign pend_next[i] = g_slot[SPK_PER_PKT-1].nxt;
  end

  // Run counter and output frame: a RUN/FIN load takes priority over the
  // handshake that would otherwise consume a timestep.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_counter <= '0;
      net_inp     <= '0;
    end else if (load) begin
      run_counter <= run_n;
      net_inp     <= pend;
    end else if (hs) begin
      run_counter <= run_counter - RUN_WIDTH'(1);
      net_inp     <= '0;
    end else if (clr_acc) begin
      net_inp     <= '0;
    end
  end

  // Pending frame: emptied on promotion or CLR, otherwise built by SPKs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else if (load || clr_acc) begin
      pend <= '0;
    end else if (spk_acc) begin
      pend <= pend_next;
    end
  end

  // Sticky clip flag, one-cycle clear pulse and the FIN marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      net_rst  <= 1'b0;
      last     <= 1'b0;
    end else begin
      net_rst <= clr_acc;
      if (clr_acc) begin
        sat_flag <= 1'b0;
      end else if (spk_acc && spk_clip) begin
        sat_flag <= 1'b1;
      end
      if (load && (op == OP_FIN)) begin
        last <= 1'b1;
      end else if (hs && net_last) begin
        last <= 1'b0;
      end
    end
  end

endmodule : network_source_batched
`default_nettype wire
